// File: rtl/ps2_keyboard_rx_pkg.sv
// Shared constants for the PS/2 keyboard receive path and the handler above it.
// Also holds the frame acceptance rule so every user applies the same check.
package ps2_keyboard_rx_pkg;

   localparam int unsigned FIFO_DEPTH_DEF = 8;
   localparam int unsigned FRAME_BITS     = 11;

   localparam logic [7:0] SC_EXTENDED = 8'hE0;
   localparam logic [7:0] SC_BREAK    = 8'hF0;

   // bits[0]=start, bits[8:1]=D0..D7, bits[9]=odd parity
   function automatic logic frame_ok(input logic [9:0] bits, input logic stop);
      return !bits[0] && stop && (^bits[9:1]);
   endfunction

endpackage

// File: rtl/ps2_keyboard_rx_lookup_table.sv
// Synchronous 256x8 ROM: Set 2 make codes to unshifted ASCII.
// Unlisted codes read as 00h.
module lookup_table
   import ps2_keyboard_rx_pkg::*;
(
   input  logic       clock,
   input  logic       clrn,
   input  logic [7:0] address,
   output logic [7:0] q
);

   logic [7:0] q_d;

   always_comb begin
      q_d = 8'h00;
      case (address)
         8'h1C: q_d = 8'h61;  8'h32: q_d = 8'h62;  8'h21: q_d = 8'h63;
         8'h23: q_d = 8'h64;  8'h24: q_d = 8'h65;  8'h2B: q_d = 8'h66;
         8'h34: q_d = 8'h67;  8'h33: q_d = 8'h68;  8'h43: q_d = 8'h69;
         8'h3B: q_d = 8'h6A;  8'h42: q_d = 8'h6B;  8'h4B: q_d = 8'h6C;
         8'h3A: q_d = 8'h6D;  8'h31: q_d = 8'h6E;  8'h44: q_d = 8'h6F;
         8'h4D: q_d = 8'h70;  8'h15: q_d = 8'h71;  8'h2D: q_d = 8'h72;
         8'h1B: q_d = 8'h73;  8'h2C: q_d = 8'h74;  8'h3C: q_d = 8'h75;
         8'h2A: q_d = 8'h76;  8'h1D: q_d = 8'h77;  8'h22: q_d = 8'h78;
         8'h35: q_d = 8'h79;  8'h1A: q_d = 8'h7A;
         8'h45: q_d = 8'h30;  8'h16: q_d = 8'h31;  8'h1E: q_d = 8'h32;
         8'h26: q_d = 8'h33;  8'h25: q_d = 8'h34;  8'h2E: q_d = 8'h35;
         8'h36: q_d = 8'h36;  8'h3D: q_d = 8'h37;  8'h3E: q_d = 8'h38;
         8'h46: q_d = 8'h39;
         8'h0E: q_d = 8'h60;  8'h4E: q_d = 8'h2D;  8'h55: q_d = 8'h3D;
         8'h5D: q_d = 8'h5C;  8'h54: q_d = 8'h5B;  8'h5B: q_d = 8'h5D;
         8'h4C: q_d = 8'h3B;  8'h52: q_d = 8'h27;  8'h41: q_d = 8'h2C;
         8'h49: q_d = 8'h2E;  8'h4A: q_d = 8'h2F;
         8'h29: q_d = 8'h20;  8'h5A: q_d = 8'h0D;  8'h66: q_d = 8'h08;
         8'h0D: q_d = 8'h09;
         8'h70: q_d = 8'h30;  8'h69: q_d = 8'h31;  8'h72: q_d = 8'h32;
         8'h7A: q_d = 8'h33;  8'h6B: q_d = 8'h34;  8'h73: q_d = 8'h35;
         8'h74: q_d = 8'h36;  8'h6C: q_d = 8'h37;  8'h75: q_d = 8'h38;
         8'h7D: q_d = 8'h39;  8'h71: q_d = 8'h2E;  8'h7C: q_d = 8'h2A;
         8'h7B: q_d = 8'h2D;  8'h79: q_d = 8'h2B;
         default: q_d = 8'h00;
      endcase
   end

   always_ff @(posedge clock or negedge clrn) begin
      if (!clrn) q <= '0;
      else       q <= q_d;
   end

endmodule

// File: rtl/ps2_keyboard_rx.sv
// PS/2 keyboard receiver: clock-edge sync, 11-bit frame check, scan-code FIFO,
// plus the scan-code-to-ASCII ROM port.
module ps2_keyboard_rx
   import ps2_keyboard_rx_pkg::*;
#(
   parameter int unsigned FIFO_DEPTH     = FIFO_DEPTH_DEF,
   parameter int unsigned TIMEOUT_CYCLES = 100000
) (
   input  logic       clk,
   input  logic       clrn,
   inout  wire        ps2_clk,
   inout  wire        ps2_data,
   input  logic       nextdata_n,
   output logic [7:0] data,
   output logic       ready,
   output logic       overflow,
   output logic       frame_err,
   input  logic [7:0] lut_addr,
   output logic [7:0] lut_q
);

   localparam int unsigned PTR_W = $clog2(FIFO_DEPTH);
   localparam int unsigned TO_W  = $clog2(TIMEOUT_CYCLES + 1);
   localparam logic [3:0]      LAST_BIT = 4'(FRAME_BITS - 1);
   localparam logic [TO_W-1:0] TO_LAST  = TO_W'(TIMEOUT_CYCLES - 1);
   localparam logic [PTR_W:0]  FULL_CNT = (PTR_W + 1)'(FIFO_DEPTH);

   logic [2:0]       sync_q;
   logic [1:0]       dsync_q;
   logic [3:0]       bit_cnt_q, bit_cnt_d;
   logic [9:0]       shift_q, shift_d;
   logic [TO_W-1:0]  idle_q, idle_d;
   logic             frame_err_q, frame_err_d;
   logic [PTR_W-1:0] wr_ptr_q, rd_ptr_q;
   logic [PTR_W:0]   count_q;
   logic             overflow_q;
   logic [7:0]       mem_q [FIFO_DEPTH];

   logic fall, push, pop, wr_en;

   assign fall = sync_q[2] & ~sync_q[1];

   // Push is combinational with the stop-bit edge so the byte lands one clk later.
   always_comb begin
      bit_cnt_d   = bit_cnt_q;
      shift_d     = shift_q;
      idle_d      = idle_q;
      frame_err_d = 1'b0;
      push        = 1'b0;
      if (fall) begin
         idle_d = '0;
         if (bit_cnt_q == LAST_BIT) begin
            bit_cnt_d = '0;
            if (frame_ok(shift_q, dsync_q[1])) push        = 1'b1;
            else                               frame_err_d = 1'b1;
         end else begin
            bit_cnt_d = bit_cnt_q + 4'd1;
            shift_d   = {dsync_q[1], shift_q[9:1]};
         end
      end else if (bit_cnt_q != '0) begin
         if (idle_q == TO_LAST) begin
            bit_cnt_d = '0;
            idle_d    = '0;
         end else begin
            idle_d = idle_q + TO_W'(1);
         end
      end else begin
         idle_d = '0;
      end
   end

   assign ready = (count_q != '0);
   assign pop   = ~nextdata_n & ready;
   assign wr_en = push & ((count_q != FULL_CNT) | pop);

   always_ff @(posedge clk or negedge clrn) begin
      if (!clrn) begin
         sync_q      <= '1;
         dsync_q     <= '1;
         bit_cnt_q   <= '0;
         shift_q     <= '0;
         idle_q      <= '0;
         frame_err_q <= 1'b0;
         wr_ptr_q    <= '0;
         rd_ptr_q    <= '0;
         count_q     <= '0;
         overflow_q  <= 1'b0;
      end else begin
         sync_q      <= {sync_q[1:0], ps2_clk};
         dsync_q     <= {dsync_q[0], ps2_data};
         bit_cnt_q   <= bit_cnt_d;
         shift_q     <= shift_d;
         idle_q      <= idle_d;
         frame_err_q <= frame_err_d;
         if (wr_en) wr_ptr_q <= wr_ptr_q + 1'b1;
         if (pop)   rd_ptr_q <= rd_ptr_q + 1'b1;
         case ({wr_en, pop})
            2'b10:   count_q <= count_q + 1'b1;
            2'b01:   count_q <= count_q - 1'b1;
            default: count_q <= count_q;
         endcase
         if (push && !wr_en) overflow_q <= 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (wr_en) mem_q[wr_ptr_q] <= shift_q[8:1];
   end

   assign data      = mem_q[rd_ptr_q];
   assign overflow  = overflow_q;
   assign frame_err = frame_err_q;

   lookup_table u_lut (
      .clock   (clk),
      .clrn    (clrn),
      .address (lut_addr),
      .q       (lut_q)
   );

endmodule

// File: tb/tb_ps2_keyboard_rx.sv
// Directed bench for ps2_keyboard_rx: frames, FIFO order/overflow, timeout,
// reset mid-frame and the ASCII ROM.
module tb_ps2_keyboard_rx;

   logic       clk = 1'b0;
   logic       clrn;
   logic       ps2_clk_drv, ps2_data_drv;
   wire        ps2_clk_w, ps2_data_w;
   logic       nextdata_n;
   logic [7:0] data;
   logic       ready, overflow, frame_err;
   logic [7:0] lut_addr, lut_q;

   int checks = 0;
   int errors = 0;
   int err_pulses = 0;

   assign ps2_clk_w  = ps2_clk_drv;
   assign ps2_data_w = ps2_data_drv;

   always #5 clk = ~clk;

   ps2_keyboard_rx #(.FIFO_DEPTH(8), .TIMEOUT_CYCLES(200)) dut (
      .clk        (clk),
      .clrn       (clrn),
      .ps2_clk    (ps2_clk_w),
      .ps2_data   (ps2_data_w),
      .nextdata_n (nextdata_n),
      .data       (data),
      .ready      (ready),
      .overflow   (overflow),
      .frame_err  (frame_err),
      .lut_addr   (lut_addr),
      .lut_q      (lut_q)
   );

   always @(negedge clk) if (frame_err === 1'b1) err_pulses++;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   // pop_at_stop lowers nextdata_n exactly in the cycle the stop bit is pushed
   task automatic send_frame(input logic [7:0] b, input logic bad_par, input logic stop,
                             input bit pop_at_stop, input int nbits);
      logic [10:0] f;
      f = {stop, (~^b) ^ bad_par, b, 1'b0};
      for (int i = 0; i < nbits; i++) begin
         @(negedge clk) ps2_data_drv = f[i];
         repeat (4) @(negedge clk);
         ps2_clk_drv = 1'b0;
         if (pop_at_stop && i == 10) begin
            repeat (2) @(negedge clk);
            nextdata_n = 1'b0;
            @(negedge clk);
            nextdata_n = 1'b1;
            repeat (5) @(negedge clk);
         end else begin
            repeat (8) @(negedge clk);
         end
         ps2_clk_drv = 1'b1;
         repeat (4) @(negedge clk);
      end
      ps2_data_drv = 1'b1;
   endtask

   task automatic pop_byte();
      @(negedge clk) nextdata_n = 1'b0;
      @(negedge clk) nextdata_n = 1'b1;
   endtask

   logic [7:0] lut_a [7] = '{8'h1C, 8'h5A, 8'h7C, 8'h05, 8'h5D, 8'h29, 8'h45};
   logic [7:0] lut_e [7] = '{8'h61, 8'h0D, 8'h2A, 8'h00, 8'h5C, 8'h20, 8'h30};

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1);
   end

   initial begin
      logic [7:0] exp_b;
      int         err0;
      clrn = 1'b0; nextdata_n = 1'b1; ps2_clk_drv = 1'b1; ps2_data_drv = 1'b1;
      lut_addr = 8'h00;
      repeat (3) @(negedge clk);
      check("rst_ready", ready, 1'b0);
      check("rst_overflow", overflow, 1'b0);
      check("rst_frame_err", frame_err, 1'b0);
      check("rst_lut_q", lut_q, 8'h00);
      clrn = 1'b1;
      repeat (2) @(negedge clk);

      send_frame(8'h1C, 1'b0, 1'b1, 0, 11);
      check("t1_ready", ready, 1'b1);
      check("t1_data", data, 8'h1C);
      pop_byte();
      check("t1_ready_after_pop", ready, 1'b0);
      pop_byte();
      check("t1_empty_pop", ready, 1'b0);

      send_frame(8'hF0, 1'b0, 1'b1, 0, 11);
      send_frame(8'h1C, 1'b0, 1'b1, 0, 11);
      check("t2_data0", data, 8'hF0);
      pop_byte();
      check("t2_data1", data, 8'h1C);
      check("t2_ready1", ready, 1'b1);
      pop_byte();
      check("t2_ready_end", ready, 1'b0);
      check("t2_no_err", err_pulses, 0);

      send_frame(8'h55, 1'b1, 1'b1, 0, 11);
      check("t3_par_err", err_pulses, 1);
      check("t3_par_ready", ready, 1'b0);
      send_frame(8'h55, 1'b0, 1'b0, 0, 11);
      check("t3_stop_err", err_pulses, 2);
      check("t3_stop_ready", ready, 1'b0);

      for (int i = 1; i <= 8; i++) send_frame(8'(i), 1'b0, 1'b1, 0, 11);
      check("t4_no_ovf_at_8", overflow, 1'b0);
      send_frame(8'h09, 1'b0, 1'b1, 0, 11);
      check("t4_ovf", overflow, 1'b1);
      check("t4_head", data, 8'h01);
      send_frame(8'h0A, 1'b0, 1'b1, 1, 11);
      for (int k = 0; k < 8; k++) begin
         exp_b = (k < 7) ? 8'(k + 2) : 8'h0A;
         check("t4_drain_ready", ready, 1'b1);
         check("t4_drain_data", data, exp_b);
         pop_byte();
      end
      check("t4_drained", ready, 1'b0);

      err0 = err_pulses;
      send_frame(8'h29, 1'b0, 1'b1, 0, 5);
      repeat (250) @(negedge clk);
      send_frame(8'h29, 1'b0, 1'b1, 0, 11);
      check("t5_ready", ready, 1'b1);
      check("t5_data", data, 8'h29);
      check("t5_no_err", err_pulses, err0);
      check("t5_ovf_sticky", overflow, 1'b1);
      pop_byte();
      check("t5_empty", ready, 1'b0);

      for (int k = 0; k < 7; k++) begin
         @(negedge clk) lut_addr = lut_a[k];
         #1 check("lut_hold", lut_q, (k == 0) ? 8'h00 : lut_e[k-1]);
         @(negedge clk);
         check("lut_q", lut_q, lut_e[k]);
      end

      send_frame(8'h11, 1'b0, 1'b1, 0, 11);
      send_frame(8'h22, 1'b0, 1'b1, 0, 11);
      send_frame(8'h33, 1'b0, 1'b1, 0, 6);
      @(negedge clk) clrn = 1'b0;
      #1;
      check("t7_rst_ready", ready, 1'b0);
      check("t7_rst_ovf", overflow, 1'b0);
      @(negedge clk) clrn = 1'b1;
      err0 = err_pulses;
      send_frame(8'h5A, 1'b0, 1'b1, 0, 11);
      check("t7_data", data, 8'h5A);
      check("t7_no_err", err_pulses, err0);
      pop_byte();
      check("t7_empty", ready, 1'b0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
